cmp_test_ctrl: RTL and testbench
================================

// Module: cmp_test_ctrl
// PURPOSE
//  Synthesizable end-of-test controller for NUM_NODES Cardinal CPU nodes (imem/dmem per node).
//  Sequence: holds nodes in reset, detects halt (trailing NOP convention), waits for pipeline flush,
//  then streams every node's DMEM contents out over a ready/valid port.
//  Replaces fixed-delay, single-node end-of-test and dump handling.
// PARAMETERS
//  NUM_NODES     4      number of CPU nodes monitored and dumped
//  ADDR_W        8      DMEM word-address width
//  DUMP_DEPTH    128    DMEM locations dumped per node, 1..2**ADDR_W
//  RESET_CYCLES  5      cycles node_reset_n is held low after own reset is released
//  HALT_CNT      4      consecutive 32'h00000000 instructions that mark a node halted
//  FLUSH_CYCLES  5      cycles waited after all nodes halt, before the dump starts
//  TIMEOUT       400000 RUN cycles before a forced flush/dump
// PORTS
//  clk           in   1              system clock
//  reset         in   1              synchronous, active-low
//  node_inst     in   32*NUM_NODES   per-node fetched instruction, node0 in the MSBs
//  node_reset_n  out  1              active-low reset driven to all nodes
//  dump_rd_en    out  1              DMEM read strobe for the dump
//  dump_rd_node  out  clog2(NUM_NODES)  node selected for the read
//  dump_rd_addr  out  ADDR_W         DMEM address for the read
//  dump_rd_data  in   64             DMEM data of the selected node, valid 1 cycle after dump_rd_en
//  dump_valid    out  1              dump word is presented on the output
//  dump_ready    in   1              sink accepts the dump word
//  dump_node     out  clog2(NUM_NODES)  node of the presented word
//  dump_addr     out  ADDR_W         address of the presented word
//  dump_data     out  64             presented word
//  halted        out  NUM_NODES      sticky per-node halt flags
//  timeout       out  1              sticky; set if TIMEOUT expired
//  cycle_count   out  32             RUN+FLUSH cycle count, saturates at 32'hFFFFFFFF
//  done          out  1              dump finished
// BEHAVIOUR
//  Reset (reset==0 at a clk edge):
//   - state=HOLD; node_reset_n=0.
//   - dump_rd_en, dump_valid, halted, timeout, done, cycle_count all 0.
//   - dump_node, dump_addr, dump_data all 0.
//   - Mid-operation reset aborts any state, including a dump in progress.
//  FSM HOLD->RUN->FLUSH->DUMP_RD->DUMP_WAIT->DUMP_OUT->...->DONE:
//   HOLD: count RESET_CYCLES cycles, then node_reset_n<=1 and go to RUN.
//   RUN:
//    - Per node, count consecutive cycles with inst==0; any non-zero value clears the count.
//    - When the count reaches HALT_CNT, set halted[n] (sticky).
//    - Go to FLUSH when all halted bits are set, or when the RUN count reaches TIMEOUT (sets timeout).
//    - If both happen in the same cycle, timeout stays 0.
//   FLUSH: wait FLUSH_CYCLES cycles; node_reset_n stays 1.
//   Dump pointer: starts at node0/addr0.
//   DUMP_RD: pulse dump_rd_en for 1 cycle with the pointer on rd_node/rd_addr.
//   DUMP_WAIT: capture dump_rd_data into dump_data/node/addr; assert dump_valid.
//   DUMP_OUT: hold the word stable while dump_valid && !dump_ready.
//    - On a ready handshake, drop dump_valid and advance the pointer (addr first, then node).
//    - Then go to DUMP_RD, or to DONE after node NUM_NODES-1, addr DUMP_DEPTH-1.
//   DONE: done=1 (sticky until reset); no further reads.
//  Timing: one read outstanding at most; minimum 3 cycles per word.
//   - Output order is node-major, address-ascending.
//  cycle_count increments in RUN and FLUSH only; saturates; frozen afterwards.
//  Halt detection runs only in RUN; instructions seen in HOLD/FLUSH are ignored.
//  Address wrap: pointer compare uses DUMP_DEPTH-1; with DUMP_DEPTH=2**ADDR_W, addr must not overflow before the compare.
// TESTING
//  1. Reset low 3 cycles, release -> node_reset_n low exactly 5 cycles, then high; all other outputs 0.
//  2. Nodes 0..3 go to NOP at cycles 10/20/30/40 -> halted 1,3,7,F in turn.
//     - FLUSH begins HALT_CNT cycles after cycle 40; first dump_rd_en FLUSH_CYCLES cycles later.
//  3. dump_ready held 1 with DMEM[n][a]={n,a} -> 4*128 words, in order, each exactly 3 cycles apart.
//     - done=1 one cycle after the last handshake.
//  4. Random dump_ready backpressure -> dump_data/node/addr stable while valid && !ready.
//     - No word lost or duplicated.
//  5. Node 2 never halts; TIMEOUT=1000 -> timeout=1, halted=4'hB, dump still completes.
//     - NOP run of HALT_CNT-1 then non-zero -> no halt.
//  6. Reset asserted during DUMP_OUT of node1/addr 40 -> all outputs return to reset values.
//     - Full sequence repeats from HOLD.

Source files
------------

// File: rtl/cmp_test_ctrl.sv
// End-of-test controller: holds the CPU nodes in reset, detects halt from trailing NOPs,
// waits out the pipeline flush, then streams every node's DMEM over a ready/valid port.
module cmp_test_ctrl #(
   parameter int NUM_NODES    = 4,
   parameter int ADDR_W       = 8,
   parameter int DUMP_DEPTH   = 128,
   parameter int RESET_CYCLES = 5,
   parameter int HALT_CNT     = 4,
   parameter int FLUSH_CYCLES = 5,
   parameter int TIMEOUT      = 400000,
   localparam int NODE_W      = (NUM_NODES > 1) ? $clog2(NUM_NODES) : 1
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic [32*NUM_NODES-1:0] node_inst,
   output logic                    node_reset_n,
   output logic                    dump_rd_en,
   output logic [NODE_W-1:0]       dump_rd_node,
   output logic [ADDR_W-1:0]       dump_rd_addr,
   input  logic [63:0]             dump_rd_data,
   output logic                    dump_valid,
   input  logic                    dump_ready,
   output logic [NODE_W-1:0]       dump_node,
   output logic [ADDR_W-1:0]       dump_addr,
   output logic [63:0]             dump_data,
   output logic [NUM_NODES-1:0]    halted,
   output logic                    timeout,
   output logic [31:0]             cycle_count,
   output logic                    done
);
   localparam int HC_W = $clog2(HALT_CNT + 1);

   typedef enum logic [2:0] {
      HOLD      = 3'd0,
      RUN       = 3'd1,
      FLUSH     = 3'd2,
      DUMP_RD   = 3'd3,
      DUMP_WAIT = 3'd4,
      DUMP_OUT  = 3'd5,
      DONE      = 3'd6
   } state_t;

   state_t              state, state_nxt;
   logic [31:0]         hold_cnt, hold_cnt_nxt;
   logic [31:0]         flush_cnt, flush_cnt_nxt;
   logic [HC_W-1:0]     zero_cnt [NUM_NODES];
   logic [HC_W-1:0]     zero_cnt_nxt [NUM_NODES];
   logic                node_reset_n_nxt, dump_rd_en_nxt, dump_valid_nxt;
   logic                timeout_nxt, done_nxt;
   logic [NODE_W-1:0]   dump_rd_node_nxt, dump_node_nxt;
   logic [ADDR_W-1:0]   dump_rd_addr_nxt, dump_addr_nxt;
   logic [63:0]         dump_data_nxt;
   logic [NUM_NODES-1:0] halted_nxt;
   logic [31:0]         cycle_count_nxt;
   logic                last_addr, last_node;

   function automatic logic [31:0] sat_inc(input logic [31:0] v);
      if (v == 32'hFFFF_FFFF) begin
         return v;
      end else begin
         return v + 32'd1;
      end
   endfunction

   // Compare in ADDR_W bits so a full-depth dump never needs an overflowed address.
   assign last_addr = (dump_rd_addr == ADDR_W'(DUMP_DEPTH - 1));
   assign last_node = (dump_rd_node == NODE_W'(NUM_NODES - 1));

   // Next-state and next-output logic for the end-of-test sequence
   always_comb begin
      state_nxt        = state;
      hold_cnt_nxt     = hold_cnt;
      flush_cnt_nxt    = flush_cnt;
      zero_cnt_nxt     = zero_cnt;
      node_reset_n_nxt = node_reset_n;
      dump_rd_en_nxt   = 1'b0;
      dump_rd_node_nxt = dump_rd_node;
      dump_rd_addr_nxt = dump_rd_addr;
      dump_valid_nxt   = dump_valid;
      dump_node_nxt    = dump_node;
      dump_addr_nxt    = dump_addr;
      dump_data_nxt    = dump_data;
      halted_nxt       = halted;
      timeout_nxt      = timeout;
      cycle_count_nxt  = cycle_count;
      done_nxt         = done;
      case (state)
         HOLD: begin
            if (hold_cnt == 32'(RESET_CYCLES - 1)) begin
               node_reset_n_nxt = 1'b1;
               state_nxt        = RUN;
            end else begin
               hold_cnt_nxt = hold_cnt + 32'd1;
            end
         end
         RUN: begin
            cycle_count_nxt = sat_inc(cycle_count);
            for (int n = 0; n < NUM_NODES; n++) begin
               if (node_inst[32*(NUM_NODES-1-n) +: 32] == 32'h0000_0000) begin
                  if (zero_cnt[n] != HC_W'(HALT_CNT)) begin
                     zero_cnt_nxt[n] = zero_cnt[n] + HC_W'(1);
                  end else begin
                     zero_cnt_nxt[n] = zero_cnt[n];
                  end
               end else begin
                  zero_cnt_nxt[n] = '0;
               end
               halted_nxt[n] = halted[n] | (zero_cnt_nxt[n] == HC_W'(HALT_CNT));
            end
            // A halt completing on the timeout cycle wins, so timeout stays clear.
            if (&halted_nxt) begin
               state_nxt = FLUSH;
            end else if (cycle_count >= 32'(TIMEOUT - 1)) begin
               timeout_nxt = 1'b1;
               state_nxt   = FLUSH;
            end else begin
               state_nxt = RUN;
            end
         end
         FLUSH: begin
            cycle_count_nxt = sat_inc(cycle_count);
            if (flush_cnt == 32'(FLUSH_CYCLES - 1)) begin
               dump_rd_en_nxt = 1'b1;
               state_nxt      = DUMP_RD;
            end else begin
               flush_cnt_nxt = flush_cnt + 32'd1;
            end
         end
         DUMP_RD: begin
            state_nxt = DUMP_WAIT;
         end
         DUMP_WAIT: begin
            dump_data_nxt  = dump_rd_data;
            dump_node_nxt  = dump_rd_node;
            dump_addr_nxt  = dump_rd_addr;
            dump_valid_nxt = 1'b1;
            state_nxt      = DUMP_OUT;
         end
         DUMP_OUT: begin
            if (dump_ready) begin
               dump_valid_nxt = 1'b0;
               if (last_addr && last_node) begin
                  done_nxt  = 1'b1;
                  state_nxt = DONE;
               end else if (last_addr) begin
                  dump_rd_addr_nxt = '0;
                  dump_rd_node_nxt = dump_rd_node + NODE_W'(1);
                  dump_rd_en_nxt   = 1'b1;
                  state_nxt        = DUMP_RD;
               end else begin
                  dump_rd_addr_nxt = dump_rd_addr + ADDR_W'(1);
                  dump_rd_en_nxt   = 1'b1;
                  state_nxt        = DUMP_RD;
               end
            end else begin
               state_nxt = DUMP_OUT;
            end
         end
         DONE: begin
            state_nxt = DONE;
         end
         default: begin
            state_nxt = HOLD;
         end
      endcase
   end

   // State and output registers with synchronous active-low reset
   always_ff @(posedge clk) begin
      if (!reset) begin
         state        <= HOLD;
         hold_cnt     <= 32'd0;
         flush_cnt    <= 32'd0;
         for (int n = 0; n < NUM_NODES; n++) begin
            zero_cnt[n] <= '0;
         end
         node_reset_n <= 1'b0;
         dump_rd_en   <= 1'b0;
         dump_rd_node <= '0;
         dump_rd_addr <= '0;
         dump_valid   <= 1'b0;
         dump_node    <= '0;
         dump_addr    <= '0;
         dump_data    <= 64'd0;
         halted       <= '0;
         timeout      <= 1'b0;
         cycle_count  <= 32'd0;
         done         <= 1'b0;
      end else begin
         state        <= state_nxt;
         hold_cnt     <= hold_cnt_nxt;
         flush_cnt    <= flush_cnt_nxt;
         zero_cnt     <= zero_cnt_nxt;
         node_reset_n <= node_reset_n_nxt;
         dump_rd_en   <= dump_rd_en_nxt;
         dump_rd_node <= dump_rd_node_nxt;
         dump_rd_addr <= dump_rd_addr_nxt;
         dump_valid   <= dump_valid_nxt;
         dump_node    <= dump_node_nxt;
         dump_addr    <= dump_addr_nxt;
         dump_data    <= dump_data_nxt;
         halted       <= halted_nxt;
         timeout      <= timeout_nxt;
         cycle_count  <= cycle_count_nxt;
         done         <= done_nxt;
      end
   end
endmodule

// File: tb/tb_cmp_test_ctrl.sv
// Bench for cmp_test_ctrl: a timestamp-based reference model of the end-of-test sequence
// checked every cycle, plus literal expectations at known cycles of each scenario.
module tb_cmp_test_ctrl;
   localparam int NN = 4, AW = 8, DEPTH = 128, RC = 5, HC = 4, FC = 5, TO = 1000;
   localparam int TOTAL = NN * DEPTH;

   logic            clk = 1'b0;
   logic            reset;
   logic [32*NN-1:0] node_inst;
   logic            node_reset_n, dump_rd_en, dump_valid, dump_ready, timeout, done;
   logic [1:0]      dump_rd_node, dump_node;
   logic [AW-1:0]   dump_rd_addr, dump_addr;
   logic [63:0]     rd_data, dump_data;
   logic [NN-1:0]   halted;
   logic [31:0]     cycle_count;

   int checks = 0, failures = 0;
   int scen = 0;
   bit rand_ready = 1'b0;

   // reference model state, all relative to k = clock edges since reset release
   bit          live = 1'b0;
   int          k = 0, m_cc = 0, run_end = 0, rd_edge = 0, w = 0;
   int          zrun [NN];
   bit          m_nrst, m_rd_en, m_valid, m_timeout, m_done, dumping;
   logic [NN-1:0] m_halted;
   logic [1:0]  m_dn;
   logic [AW-1:0] m_da;
   logic [63:0] m_dd;

   cmp_test_ctrl #(.TIMEOUT(TO)) dut (
      .clk(clk), .reset(reset), .node_inst(node_inst), .node_reset_n(node_reset_n),
      .dump_rd_en(dump_rd_en), .dump_rd_node(dump_rd_node), .dump_rd_addr(dump_rd_addr),
      .dump_rd_data(rd_data), .dump_valid(dump_valid), .dump_ready(dump_ready),
      .dump_node(dump_node), .dump_addr(dump_addr), .dump_data(dump_data),
      .halted(halted), .timeout(timeout), .cycle_count(cycle_count), .done(done)
   );

   always #5 clk = ~clk;

   function automatic logic [63:0] mem_word(input int n, input int a);
      return {16'hC0DE, 16'(n), 16'(a * 13 + 7), 16'(a)};
   endfunction

   // DMEM of all nodes: data one cycle after the read strobe, garbage otherwise
   always @(posedge clk) begin
      rd_data <= dump_rd_en ? mem_word(int'(dump_rd_node), int'(dump_rd_addr)) : {$urandom, $urandom};
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s k=%0d scen=%0d actual=%0h required=%0h", name, k, scen, act, exp);
      end
   endtask

   // Reference model: phases are derived from timestamps (hold, run end, flush end, read edge)
   always @(posedge clk) begin
      if (reset === 1'b0) begin
         live = 1'b1; k = 0; m_cc = 0; run_end = 0; rd_edge = 0; w = 0;
         m_nrst = 1'b0; m_rd_en = 1'b0; m_valid = 1'b0; m_timeout = 1'b0; m_done = 1'b0;
         dumping = 1'b0; m_halted = '0; m_dn = '0; m_da = '0; m_dd = 64'd0;
         for (int n = 0; n < NN; n++) zrun[n] = 0;
      end else if (live) begin
         k++;
         m_rd_en = 1'b0;
         if (k <= RC) begin
            if (k == RC) m_nrst = 1'b1;
         end else if (run_end == 0) begin
            m_cc++;
            for (int n = 0; n < NN; n++) begin
               if (node_inst[32*(NN-1-n) +: 32] == 32'h0) zrun[n]++;
               else zrun[n] = 0;
               if (zrun[n] >= HC) m_halted[n] = 1'b1;
            end
            if (&m_halted) run_end = k;
            else if (m_cc == TO) begin
               m_timeout = 1'b1;
               run_end = k;
            end
         end else if (k <= run_end + FC) begin
            m_cc++;
            if (k == run_end + FC) begin
               dumping = 1'b1; rd_edge = k; w = 0; m_rd_en = 1'b1;
            end
         end else if (dumping) begin
            if (k == rd_edge + 2) begin
               m_valid = 1'b1;
               m_dn = 2'(w / DEPTH);
               m_da = AW'(w % DEPTH);
               m_dd = mem_word(w / DEPTH, w % DEPTH);
            end else if (k >= rd_edge + 3 && dump_ready) begin
               m_valid = 1'b0;
               w++;
               if (w == TOTAL) begin
                  dumping = 1'b0;
                  m_done = 1'b1;
               end else begin
                  rd_edge = k;
                  m_rd_en = 1'b1;
               end
            end
         end
      end
   end

   // Compare DUT against the model every cycle, plus literal expectations
   always @(negedge clk) begin
      if (live) begin
         chk("node_reset_n", 64'(node_reset_n), 64'(m_nrst));
         chk("dump_rd_en", 64'(dump_rd_en), 64'(m_rd_en));
         if (m_rd_en) begin
            chk("dump_rd_node", 64'(dump_rd_node), 64'(w / DEPTH));
            chk("dump_rd_addr", 64'(dump_rd_addr), 64'(w % DEPTH));
         end
         chk("dump_valid", 64'(dump_valid), 64'(m_valid));
         chk("dump_node", 64'(dump_node), 64'(m_dn));
         chk("dump_addr", 64'(dump_addr), 64'(m_da));
         chk("dump_data", dump_data, m_dd);
         chk("halted", 64'(halted), 64'(m_halted));
         chk("timeout", 64'(timeout), 64'(m_timeout));
         chk("cycle_count", 64'(cycle_count), 64'(m_cc));
         chk("done", 64'(done), 64'(m_done));
         if (scen == 1 || scen == 5) begin
            case (k)
               4:    chk("lit_nrst_k4", 64'(node_reset_n), 64'd0);
               5:    chk("lit_nrst_k5", 64'(node_reset_n), 64'd1);
               12:   chk("lit_halted_k12", 64'(halted), 64'h0);
               13:   chk("lit_halted_k13", 64'(halted), 64'h1);
               23:   chk("lit_halted_k23", 64'(halted), 64'h3);
               33:   chk("lit_halted_k33", 64'(halted), 64'h7);
               43:   chk("lit_halted_k43", 64'(halted), 64'hF);
               44:   chk("lit_model_run_end", 64'(run_end), 64'd43);
               47:   chk("lit_rd_en_k47", 64'(dump_rd_en), 64'd0);
               48:   chk("lit_rd_en_k48", 64'(dump_rd_en), 64'd1);
               1583: chk("lit_done_k1583", 64'(done), 64'd0);
               1584: begin
                  chk("lit_done_k1584", 64'(done), 64'd1);
                  chk("lit_cycle_count_final", 64'(cycle_count), 64'd43);
               end
               default: ;
            endcase
         end
         if (scen == 3) begin
            case (k)
               1004: chk("lit_timeout_k1004", 64'(timeout), 64'd0);
               1005: begin
                  chk("lit_timeout_k1005", 64'(timeout), 64'd1);
                  chk("lit_halted_timeout", 64'(halted), 64'hB);
               end
               1010: begin
                  chk("lit_rd_en_k1010", 64'(dump_rd_en), 64'd1);
                  chk("lit_cycle_count_timeout", 64'(cycle_count), 64'd1005);
               end
               default: ;
            endcase
         end
      end
   end

   function automatic logic [31:0] inst_for(input int n, input int t);
      if (scen == 2 && t <= RC) return 32'h0;
      if (scen == 3 && n == 2) return ((t % 4) == 0) ? ($urandom | 32'h1) : 32'h0;
      return (t >= 10 * (n + 1)) ? 32'h0 : ($urandom | 32'h1);
   endfunction

   task automatic step();
      @(negedge clk);
      #1;
      for (int n = 0; n < NN; n++) node_inst[32*(NN-1-n) +: 32] = inst_for(n, k + 1);
      dump_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
   endtask

   task automatic apply_reset(input int cycles);
      @(negedge clk);
      #1;
      reset = 1'b0;
      repeat (cycles) step();
      reset = 1'b1;
   endtask

   task automatic run_until_done(input int budget, input string tag);
      int c = 0;
      while (done !== 1'b1 && c < budget) begin
         step();
         c++;
      end
      checks++;
      if (done !== 1'b1) begin
         failures++;
         $display("FAIL %s_done_wait actual=%0b required=1 after %0d cycles", tag, done, c);
      end
      repeat (6) step();
   endtask

   initial begin
      int c;
      reset = 1'b0;
      node_inst = '0;
      dump_ready = 1'b0;
      rand_ready = 1'b0;
      apply_reset(3);
      scen = 1;
      run_until_done(2500, "normal");

      rand_ready = 1'b1;
      apply_reset(2);
      scen = 2;
      run_until_done(6000, "backpressure");

      rand_ready = 1'b0;
      apply_reset(2);
      scen = 3;
      run_until_done(4000, "timeout");

      rand_ready = 1'b1;
      apply_reset(2);
      scen = 4;
      c = 0;
      while (!(m_valid && w == DEPTH + 40) && c < 3000) begin
         step();
         c++;
      end
      chk("abort_point_valid", 64'(dump_valid), 64'd1);
      chk("abort_point_node", 64'(dump_node), 64'd1);
      chk("abort_point_addr", 64'(dump_addr), 64'd40);

      rand_ready = 1'b0;
      apply_reset(3);
      scen = 5;
      run_until_done(2500, "rerun");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
